// File: rtl/alu_exec_stage.sv
// Two-stage execute stage wrapping an external combinational ALU: S1 holds the accepted op, S2 the result.
// Optional status flags (out_zero/out_neg) are enabled by defining ALU_EXEC_FLAGS_EN.
module alu_exec_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FUNCT_W = 2,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNCT_W-1:0] in_funct,
    input  logic [DATA_W-1:0]  in_op_a,
    input  logic [DATA_W-1:0]  in_op_b,
    input  logic               in_fwd_a,
    input  logic               in_fwd_b,
    input  logic [TAG_W-1:0]   in_dst,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [FUNCT_W-1:0] alu_funct,
    input  logic [DATA_W-1:0]  alu_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [TAG_W-1:0]   out_dst,
    output logic [CNT_W-1:0]   retired
`ifdef ALU_EXEC_FLAGS_EN
    ,
    output logic               out_zero,
    output logic               out_neg
`endif
);

    logic               s1_valid;
    logic [FUNCT_W-1:0] s1_funct;
    logic [DATA_W-1:0]  s1_a;
    logic [DATA_W-1:0]  s1_b;
    logic               s1_fwd_a;
    logic               s1_fwd_b;
    logic [TAG_W-1:0]   s1_dst;
    logic [DATA_W-1:0]  last_result;

    logic advance;
    logic accept;
    logic transfer;

    // S2 can take a new result when it is empty or being drained this cycle
    assign advance  = !out_valid || out_ready;
    assign in_ready = !s1_valid || advance;
    assign accept   = in_valid && in_ready;
    assign transfer = s1_valid && advance;

    assign alu_a     = s1_fwd_a ? last_result : s1_a;
    assign alu_b     = s1_fwd_b ? last_result : s1_b;
    assign alu_funct = s1_funct;

    // S1 operand register; payload is reset too so the ALU never sees X
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_funct <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_fwd_a <= 1'b0;
            s1_fwd_b <= 1'b0;
            s1_dst   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_funct <= in_funct;
            s1_a     <= in_op_a;
            s1_b     <= in_op_b;
            s1_fwd_a <= in_fwd_a;
            s1_fwd_b <= in_fwd_b;
            s1_dst   <= in_dst;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 result register; last_result tracks the most recent op to leave S1
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_dst     <= '0;
            last_result <= '0;
        end else if (transfer) begin
            out_valid   <= 1'b1;
            out_data    <= alu_out;
            out_dst     <= s1_dst;
            last_result <= alu_out;
        end else if (advance) begin
            out_valid   <= 1'b0;
        end
    end

    // Saturating retirement counter
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (out_valid && out_ready && (retired != {CNT_W{1'b1}})) begin
            retired <= retired + CNT_W'(1);
        end
    end

`ifdef ALU_EXEC_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (transfer) begin
            out_zero <= (alu_out == '0);
            out_neg  <= alu_out[DATA_W-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: table of ops plus hand-written stall, forwarding, reset and saturation sequences.
module tb_alu_exec_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_funct;
    logic [31:0] in_op_a;
    logic [31:0] in_op_b;
    logic        in_fwd_a;
    logic        in_fwd_b;
    logic [3:0]  in_dst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_funct;
    logic [31:0] alu_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_dst;
    logic [15:0] retired;

    logic        in_ready_s;
    logic [31:0] alu_a_s;
    logic [31:0] alu_b_s;
    logic [1:0]  alu_funct_s;
    logic [31:0] alu_out_s;
    logic        out_valid_s;
    logic [31:0] out_data_s;
    logic [3:0]  out_dst_s;
    logic [3:0]  retired_s;

`ifdef ALU_EXEC_FLAGS_EN
    logic out_zero, out_neg, out_zero_s, out_neg_s;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [35:0] exp_q[$];
    logic [35:0] mon_e;

    function automatic logic [31:0] alu_f(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return 32'($signed(a) >>> b[4:0]);
        endcase
    endfunction

    assign alu_out   = alu_f(alu_funct, alu_a, alu_b);
    assign alu_out_s = alu_f(alu_funct_s, alu_a_s, alu_b_s);

    alu_exec_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_op_a(in_op_a), .in_op_b(in_op_b),
        .in_fwd_a(in_fwd_a), .in_fwd_b(in_fwd_b), .in_dst(in_dst),
        .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dst(out_dst), .retired(retired)
`ifdef ALU_EXEC_FLAGS_EN
        , .out_zero(out_zero), .out_neg(out_neg)
`endif
    );

    alu_exec_stage #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_funct(in_funct), .in_op_a(in_op_a), .in_op_b(in_op_b),
        .in_fwd_a(in_fwd_a), .in_fwd_b(in_fwd_b), .in_dst(in_dst),
        .alu_a(alu_a_s), .alu_b(alu_b_s), .alu_funct(alu_funct_s), .alu_out(alu_out_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_dst(out_dst_s), .retired(retired_s)
`ifdef ALU_EXEC_FLAGS_EN
        , .out_zero(out_zero_s), .out_neg(out_neg_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every handshaked result must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: got %h expected none at %0t", out_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", out_data, mon_e[31:0]);
                chk("out_dst", 32'(out_dst), 32'(mon_e[35:32]));
`ifdef ALU_EXEC_FLAGS_EN
                chk("out_zero", 32'(out_zero), 32'(mon_e[31:0] == 32'd0));
                chk("out_neg", 32'(out_neg), 32'(mon_e[31]));
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        step(1);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic send(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic fa, input logic fb, input logic [3:0] d,
                        input logic [31:0] exp, output int waits);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_funct = f;
        in_op_a  = a;
        in_op_b  = b;
        in_fwd_a = fa;
        in_fwd_b = fb;
        in_dst   = d;
        exp_q.push_back({d, exp});
        waits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = in_ready;
            step(1);
            if (ok) break;
            waits++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    typedef struct {
        logic [1:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic        fa;
        logic        fb;
        logic [3:0]  dst;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int w;
        vecs[0] = '{2'b00, 32'd5,          32'd7,          1'b0, 1'b0, 4'd1,  32'd12};
        vecs[1] = '{2'b01, 32'd10,         32'd3,          1'b0, 1'b0, 4'd2,  32'd7};
        vecs[2] = '{2'b10, 32'h0000_F0F0,  32'h0000_0FF0,  1'b0, 1'b0, 4'd3,  32'h0000_00F0};
        vecs[3] = '{2'b11, 32'h8000_0000,  32'd4,          1'b0, 1'b0, 4'd4,  32'hF800_0000};
        vecs[4] = '{2'b01, 32'd5,          32'd5,          1'b0, 1'b0, 4'd5,  32'd0};
        vecs[5] = '{2'b01, 32'd3,          32'd5,          1'b0, 1'b0, 4'd6,  32'hFFFF_FFFE};
        vecs[6] = '{2'b00, 32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 4'd7,  32'd0};
        vecs[7] = '{2'b11, 32'h7FFF_FFF0,  32'd4,          1'b0, 1'b0, 4'd8,  32'h07FF_FFFF};
        vecs[8] = '{2'b00, 32'hDEAD_BEEF,  32'd1,          1'b1, 1'b0, 4'd9,  32'h0800_0000};
        vecs[9] = '{2'b01, 32'h1234_5678,  32'h9ABC_DEF0,  1'b1, 1'b1, 4'd10, 32'd0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_funct = '0; in_op_a = '0; in_op_b = '0; in_fwd_a = 1'b0; in_fwd_b = 1'b0; in_dst = '0;
        step(2);
        rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_dst", 32'(out_dst), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single add with explicit latency checks
        out_ready = 1'b1;
        send(2'b00, 32'd5, 32'd7, 1'b0, 1'b0, 4'hC, 32'd12, w);
        chk("lat_valid_early", 32'(out_valid), 32'd0);
        step(1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", out_data, 32'd12);
        chk("lat_dst", 32'(out_dst), 32'hC);
        step(1);
        chk("lat_retired", 32'(retired), 32'd1);
        chk("lat_valid_clear", 32'(out_valid), 32'd0);

        // Table ops issued back-to-back; each must be accepted without waiting
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].fa, vecs[i].fb, vecs[i].dst, vecs[i].exp, w);
            chk("table_throughput", 32'(w), 32'd0);
        end
        drain();
        chk("table_retired", 32'(retired), 32'd11);

        // Forwarding back-to-back
        do_reset();
        out_ready = 1'b1;
        send(2'b00, 32'd1, 32'd2, 1'b0, 1'b0, 4'd1, 32'd3, w);
        send(2'b00, 32'd0, 32'd4, 1'b1, 1'b0, 4'd2, 32'd7, w);
        drain();
        chk("fwd_retired", 32'(retired), 32'd2);

        // Forwarding with op2 parked in S1 while op1 stalls in S2
        do_reset();
        out_ready = 1'b0;
        send(2'b00, 32'd1, 32'd2, 1'b0, 1'b0, 4'd1, 32'd3, w);
        send(2'b00, 32'd0, 32'd4, 1'b1, 1'b0, 4'd2, 32'd7, w);
        for (int i = 0; i < 2; i++) begin
            chk("fwd_stall_hold", out_data, 32'd3);
            chk("fwd_stall_ready", 32'(in_ready), 32'd0);
            step(1);
        end
        drain();
        chk("fwd_stall_retired", 32'(retired), 32'd2);

        // Backpressure: third op waits while both stages are full
        do_reset();
        out_ready = 1'b0;
        send(2'b00, 32'd100, 32'd1, 1'b0, 1'b0, 4'd1, 32'd101, w);
        send(2'b01, 32'd100, 32'd1, 1'b0, 1'b0, 4'd2, 32'd99, w);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_funct = 2'b10; in_op_a = 32'hFF; in_op_b = 32'h0F;
        in_fwd_a = 1'b0; in_fwd_b = 1'b0; in_dst = 4'd3;
        exp_q.push_back({4'd3, 32'h0F});
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_data", out_data, 32'd101);
            chk("bp_hold_dst", 32'(out_dst), 32'd1);
            chk("bp_stall_ready", 32'(in_ready), 32'd0);
            step(1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step(1);
        in_valid = 1'b0;
        drain();
        step(2);
        chk("bp_retired", 32'(retired), 32'd3);

        // Reset with both stages full and an op offered in the reset cycle
        send(2'b00, 32'd2, 32'd2, 1'b0, 1'b0, 4'd4, 32'd4, w);
        drain();
        out_ready = 1'b0;
        send(2'b00, 32'd1, 32'd1, 1'b0, 1'b0, 4'd5, 32'd2, w);
        send(2'b00, 32'd3, 32'd3, 1'b0, 1'b0, 4'd6, 32'd6, w);
        in_valid = 1'b1; in_op_a = 32'd50; in_op_b = 32'd50; in_dst = 4'd7;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_retired", 32'(retired), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        step(2);
        chk("mid_rst_dropped", 32'(out_valid), 32'd0);
        send(2'b00, 32'd77, 32'd9, 1'b1, 1'b0, 4'd8, 32'd9, w);
        drain();
        chk("mid_rst_after_retired", 32'(retired), 32'd1);

        // Counter saturation on the CNT_W=4 instance
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send(2'b00, 32'(i), 32'd0, 1'b0, 1'b0, 4'(i), 32'(i), w);
        drain();
        step(2);
        chk("sat_at_15", 32'(retired_s), 32'd15);
        for (int i = 0; i < 2; i++) send(2'b00, 32'd40, 32'(i), 1'b0, 1'b0, 4'd0, 32'(40 + i), w);
        drain();
        step(2);
        chk("sat_held", 32'(retired_s), 32'd15);
        chk("wide_retired", 32'(retired), 32'd17);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
